// File: rtl/lsr32_seq.sv
// Multi-cycle 32-bit logical/arithmetic right shifter.
// Shifts at most 3 bit positions per cycle and pulses done for one cycle when the result is ready.
module lsr32_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] d_in,
    input  logic [4:0]  shamt,
    output logic [31:0] d_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  count_q, count_d;
    logic        op_q, op_d;
    logic [2:0]  step;
    logic [4:0]  remain;
    logic [31:0] lsr_val;
    logic [31:0] asr_val;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            data_q  <= 32'h0000_0000;
            count_q <= 5'd0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        op_d    = op_q;
        step    = (count_q >= 5'd3) ? 3'd3 : count_q[2:0];
        remain  = count_q - {2'b00, step};
        lsr_val = data_q >> step;
        // The sign bit stays in place after an arithmetic shift, so it always
        // holds the original operand's bit 31.
        asr_val = $signed(data_q) >>> step;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = d_in;
                    count_d = shamt;
                    op_d    = op;
                    state_d = (shamt != 5'd0) ? StShift : StDone;
                end
            end
            StShift: begin
                data_d  = op_q ? asr_val : lsr_val;
                count_d = remain;
                if (remain == 5'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign d_out = data_q;
    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone);

endmodule

// File: tb/tb_lsr32_seq.sv
// Self-checking bench for lsr32_seq: directed corner cases plus random
// back-to-back operations compared against a plain >> / >>> reference.
module tb_lsr32_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [31:0] d_in;
    logic [4:0]  shamt;
    logic [31:0] d_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    lsr32_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .d_in    (d_in),
        .shamt   (shamt),
        .d_out   (d_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic o, input logic [31:0] d,
                                              input logic [4:0] n);
        logic signed [31:0] sd;
        logic [31:0] r;
        sd = d;
        if (o) r = sd >>> n;
        else   r = d >> n;
        return r;
    endfunction

    function automatic int ref_latency(input logic [4:0] n);
        if (n == 5'd0) return 1;
        return (int'(n) + 2) / 3 + 1;
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Returns at the negedge of the done
    // cycle. With scramble set, start stays high and the operand inputs change
    // every cycle while the operation is in progress.
    task automatic run_op(input logic o, input logic [31:0] d, input logic [4:0] n,
                          input bit scramble, output logic [31:0] result);
        int lat;
        int cyc;
        bit seen;
        lat  = ref_latency(n);
        seen = 0;
        check32("idle_before_start", {30'd0, busy, done}, 32'd0);
        start = 1'b1;
        op    = o;
        d_in  = d;
        shamt = n;
        @(posedge clk);
        #1;
        if (!scramble) start = 1'b0;
        for (cyc = 1; cyc <= 15 && !seen; cyc++) begin
            if (scramble) begin
                op    = 1'($urandom);
                d_in  = $urandom;
                shamt = 5'($urandom);
            end
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                check_int("done_latency", cyc, lat);
                check32("done_busy", {31'd0, busy}, 32'd1);
                check32("result", d_out, ref_shift(o, d, n));
            end else begin
                check32("busy_in_progress", {30'd0, busy, done}, 32'd2);
            end
        end
        if (!seen) check_int("done_timeout", 0, 1);
        result = d_out;
    endtask

    logic [31:0] res;
    logic        r_op;
    logic [31:0] r_d;
    logic [4:0]  r_n;

    initial begin
        reset_n = 1'b0;
        start   = 1'b1;
        op      = 1'b1;
        d_in    = 32'hDEAD_BEEF;
        shamt   = 5'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // start held high during reset must not be accepted
        check32("reset_dout", d_out, 32'h0000_0000);
        check32("reset_busy_done", {30'd0, busy, done}, 32'd0);

        // Start on the first edge with reset released
        reset_n = 1'b1;
        run_op(1'b0, 32'h8000_0000, 5'd31, 1'b0, res);
        check32("lsr_8000_by_31", res, 32'h0000_0001);
        @(negedge clk);

        run_op(1'b1, 32'h8000_0000, 5'd4, 1'b0, res);
        check32("asr_8000_by_4", res, 32'hF800_0000);
        @(negedge clk);
        check32("hold_in_idle", d_out, 32'hF800_0000);

        run_op(1'b1, 32'h7FFF_FFFF, 5'd31, 1'b0, res);
        check32("asr_7fff_by_31", res, 32'h0000_0000);
        @(negedge clk);
        run_op(1'b1, 32'h8000_0001, 5'd31, 1'b0, res);
        check32("asr_neg_by_31", res, 32'hFFFF_FFFF);
        @(negedge clk);

        run_op(1'b0, 32'h1234_5678, 5'd0, 1'b0, res);
        check32("lsr_by_0", res, 32'h1234_5678);
        @(negedge clk);
        run_op(1'b1, 32'h1234_5678, 5'd0, 1'b0, res);
        check32("asr_by_0", res, 32'h1234_5678);
        @(negedge clk);

        // start pulsed with different operands while shifting
        run_op(1'b0, 32'hF000_0000, 5'd7, 1'b1, res);
        check32("ignore_start_in_shift", res, 32'h01E0_0000);
        start = 1'b0;
        @(negedge clk);
        check32("no_extra_done", {30'd0, busy, done}, 32'd0);

        // Reset in the middle of an LSR by 20
        start = 1'b1;
        op    = 1'b0;
        d_in  = 32'hFFFF_0000;
        shamt = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check32("midreset_c1", {30'd0, busy, done}, 32'd2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check32("midreset_busy_done", {30'd0, busy, done}, 32'd0);
        check32("midreset_dout", d_out, 32'h0000_0000);
        @(negedge clk);
        check32("midreset_no_done", {30'd0, busy, done}, 32'd0);
        run_op(1'b0, 32'hFFFF_0000, 5'd20, 1'b0, res);
        check32("after_midreset", res, 32'h0000_0FFF);

        // Back-to-back random operations with start held high throughout
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            r_op = 1'($urandom);
            r_d  = $urandom;
            r_n  = 5'($urandom);
            run_op(r_op, r_d, r_n, 1'b1, res);
        end
        start = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsr32_seq.md
LSR32_SEQ -- requirements
Module: lsr32_seq

Interface
- REQ-001 SHALL have no parameters; data width is fixed at 32 bits, shift amount width at 5 bits, and maximum step per cycle at 3 bits.
- REQ-002 SHALL have port `clk`: input, 1 bit, sole clock; all state updates on the rising edge.
- REQ-003 SHALL have port `reset_n`: input, 1 bit; reset is synchronous and active-low.
- REQ-004 SHALL have port `start`: input, 1 bit; request to begin a shift.
- REQ-005 SHALL have port `op`: input, 1 bit; 0 selects logical shift right (zero fill), 1 selects arithmetic shift right (sign fill).
- REQ-006 SHALL have port `d_in`: input, 32 bits; operand.
- REQ-007 SHALL have port `shamt`: input, 5 bits; shift amount, 0 to 31.
- REQ-008 SHALL have port `d_out`: output, 32 bits, registered; result.
- REQ-009 SHALL have port `busy`: output, 1 bit; high while state is not IDLE.
- REQ-010 SHALL have port `done`: output, 1 bit; single-cycle completion pulse.

Function
- REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE.
- REQ-012 SHALL, in IDLE with `start`=1, on that edge latch `d_in` into the data register, `shamt` into the count register, and `op` into the op register; next state is SHIFT if `shamt`≠0, otherwise DONE.
- REQ-013 SHALL, on each SHIFT edge, set step = min(count, 3); shift the data register right by step; fill vacated MSBs with 0 (LSR) or with latched bit 31 (ASR); and set count = count − step.
- REQ-014 SHALL go to DONE when count − step = 0; otherwise it SHALL remain in SHIFT.
- REQ-015 SHALL assert `done`=1 for exactly one cycle while in DONE, with the final result on `d_out`; the next state is unconditionally IDLE.
- REQ-016 SHALL have latency: `done` high ceil(N/3)+1 cycles after the start edge for N>0, and 1 cycle after it for N=0.
- REQ-017 SHALL ignore `start` in SHIFT and DONE, with no effect on any register.
- REQ-018 SHALL use the latched `op` and `shamt`; changes on the inputs after acceptance SHALL NOT affect the operation in progress.
- REQ-019 SHALL drive `d_out` directly from the data register; intermediate values are visible during SHIFT and are valid only when `done`=1.
- REQ-020 SHALL hold `d_out` in IDLE until the next accepted `start`.
- REQ-021 SHALL, for ASR, replicate the original sign bit at every step, so that ASR of a negative operand by 31 gives 0xFFFFFFFF.
- REQ-022 SHALL accept `start` in the IDLE cycle immediately following DONE (back-to-back), with no dead cycle beyond IDLE.

Reset
- REQ-023 SHALL, when `reset_n`=0 at a rising edge, force state to IDLE and clear the data, count and op registers to 0; `d_out`=0x00000000, `busy`=0, `done`=0.
- REQ-024 SHALL give reset priority over `start` and over any state, including mid-SHIFT; the operation in progress is abandoned without asserting `done`.
- REQ-025 SHALL accept `start` on the first edge with `reset_n`=1.

Verification
- REQ-026 SHALL be verified by: LSR, `d_in`=0x80000000, `shamt`=31 → `done` 12 cycles after start; `d_out`=0x00000001; `busy` high for cycles 1–12.
- REQ-027 SHALL be verified by: ASR, `d_in`=0x80000000, `shamt`=4 → `done` at cycle 3; `d_out`=0xF8000000. Also ASR, `d_in`=0x7FFFFFFF, `shamt`=31 → `d_out`=0x00000000.
- REQ-028 SHALL be verified by: `shamt`=0, `d_in`=0x12345678, either `op` → `done` at cycle 1; `d_out`=0x12345678.
- REQ-029 SHALL be verified by: `start` pulsed during SHIFT with a different `d_in`/`shamt` → first result unaffected (LSR 0xF0000000 by 7 → 0x01E00000); no extra `done`.
- REQ-030 SHALL be verified by: `reset_n`=0 at cycle 2 of an LSR by 20 → next cycle `busy`=0, `d_out`=0; no `done` pulse; a new start then completes normally.
- REQ-031 SHALL be verified by: back-to-back, with `start` held high continuously → each operation completes and the next is accepted in the IDLE cycle after `done`; the results match a reference `>>` / `>>>` model for 1000 random operand/`shamt`/`op` triples.
